keypad_debounce: RTL and testbench

KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

---
 rtl/keypad_debounce_pkg.sv | 23 ++
 rtl/keypad_debounce_sync_2ff.sv | 27 ++
 rtl/keypad_debounce.sv | 158 +++++++++++++++
 tb/tb_keypad_debounce.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_debounce_pkg.sv
// Shared types for the keypad debouncer: FSM state encoding, key/code widths,
// and the priority encoder that turns the active-low key vector into a BCD digit.
package keypad_debounce_pkg;

  localparam int CODE_W = 4;
  localparam int KEYS   = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  // Highest pressed index wins when several keys are down together.
  function automatic logic [CODE_W-1:0] top_key(input logic [KEYS-1:0] keys_n);
    top_key = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (!keys_n[i]) top_key = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_debounce_sync_2ff.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all ones
// so that a reset keypad reads as fully released.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debouncer: press accepted after DEBOUNCE_CYCLES stable cycles, key_valid lands DEBOUNCE_CYCLES+3 cycles after the edge.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held key after REPEAT_DELAY, then every REPEAT_PERIOD cycles.
module keypad_debounce
  import keypad_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [KEYS-1:0]   A,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_busy
);

  localparam int MAX_P = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                       ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                       : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CNT_W = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEYS-1:0]   a_sync;
  logic              pressed;
  logic [CODE_W-1:0] code;

  kp_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              accept;

  sync_2ff #(.WIDTH(KEYS)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (A),
    .q   (a_sync)
  );

  assign pressed = (a_sync != '1);
  assign code    = top_key(a_sync);
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_code_d = key_code_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_DB;
          cand_d  = code;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (code != cand_q) begin
          cand_d = code;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d    = HELD;
          key_code_d = cand_q;
          accept     = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        // Code changes while held are deliberately ignored until full release.
        if (!pressed) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_fire;

  // Every pressed cycle after acceptance counts toward the next repeat, including a re-press seen in RELEASE_DB.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (accept) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (pressed && (state_q == HELD || state_q == RELEASE_DB)) begin
      if (rpt_q == (rpt_first_q ? RD_LAST : RP_LAST) && !key_valid_q) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = (rpt_q == CNT_SAT) ? rpt_q : rpt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign key_valid_d = accept | rpt_fire;
`else
  assign key_valid_d = accept;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Outputs are forced quiet for the whole reset window, including its first cycle.
  assign key_valid = key_valid_q & ~RST;
  assign key_busy  = (state_q != IDLE) & ~RST;
  assign key_code  = RST ? '0 : key_code_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: run-length reference model checked every cycle, plus directed literal expectations.
module tb_keypad_debounce;
  import keypad_debounce_pkg::*;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] A   = 10'h3FF;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_busy;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;
  logic chk_en = 1'b0;
  logic prev_valid = 1'b0;

  always #5 CLK = ~CLK;

  keypad_debounce #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_busy  (key_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] hi_key(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) begin
      if (!s[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  // Reference model: synchronizer as a two-deep delay line, then acceptance by
  // run lengths of stable pressed / released cycles.
  logic [9:0] m_s1 = 10'h3FF, m_s2 = 10'h3FF;
  int         m_phase = 0, m_run = 0, m_rel = 0, m_hold = 0;
  logic [3:0] m_run_code = '0, m_code = '0;
  logic       m_valid = 1'b0, m_busy = 1'b0;

  always @(posedge CLK) begin : model
    logic       p;
    logic [3:0] c;
    if (RST) begin
      m_s1 = 10'h3FF; m_s2 = 10'h3FF;
      m_phase = 0; m_run = 0; m_rel = 0; m_hold = 0;
      m_code = '0; m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      p = (m_s2 != 10'h3FF);
      c = hi_key(m_s2);
      m_valid = 1'b0;
      if (m_phase == 0) begin
        if (p) begin
          if (m_run > 0 && c == m_run_code) m_run++;
          else begin m_run = 1; m_run_code = c; end
        end else m_run = 0;
        if (m_run == D + 1) begin
          m_phase = 1; m_valid = 1'b1; m_code = m_run_code;
          m_run = 0; m_rel = 0; m_hold = 0;
        end
        m_busy = (m_phase == 1) || (m_run > 0);
      end else begin
        if (p) begin
          m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
          m_hold++;
          if (m_hold >= RD && (m_hold - RD) % RP == 0) m_valid = 1'b1;
`endif
        end else m_rel++;
        if (m_rel == D + 1) begin m_phase = 0; m_rel = 0; end
        m_busy = (m_phase == 1);
      end
      m_s2 = m_s1;
      m_s1 = A;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_valid", key_valid, RST ? 1'b0 : m_valid);
      chk("model_busy",  key_busy,  RST ? 1'b0 : m_busy);
      chk("model_code",  key_code,  RST ? 4'd0 : m_code);
      chk("no_double_strobe", key_valid & prev_valid, 0);
      if (key_valid) strobes++;
      prev_valid = key_valid;
    end
  end

  task automatic cyc_wait();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [9:0] a, input int n);
    A = a;
    repeat (n) cyc_wait();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0;
    cyc_wait();
    chk_en = 1'b1;
    repeat (2) cyc_wait();
    chk("rst_valid", key_valid, 0);
    chk("rst_busy", key_busy, 0);
    chk("rst_code", key_code, 0);
    RST = 1'b0;
    repeat (3) cyc_wait();

    // Key 3 held: strobe at cycle 7 only, busy from cycle 3.
    A = 10'h3F7;
    for (int k = 1; k <= 10; k++) begin
      cyc_wait();
      chk("t1_valid", key_valid, (k == 7));
      chk("t1_busy", key_busy, (k >= 3));
      if (k == 7) chk("t1_code", key_code, 3);
    end
    hold(10'h3FF, 14);
    chk("t1_idle", key_busy, 0);
    chk("t1_code_hold", key_code, 3);

    // Two-cycle bounce on key 5.
    s0 = strobes;
    hold(10'h3DF, 2);
    hold(10'h3FF, 12);
    chk("t2_no_strobe", strobes - s0, 0);
    chk("t2_idle", key_busy, 0);
    chk("t2_code_hold", key_code, 3);

    // Keys 2 and 8 together, then 8 released while 2 is still down.
    s0 = strobes;
    A = 10'h2FB;
    for (int k = 1; k <= 10; k++) begin
      cyc_wait();
      chk("t3_valid", key_valid, (k == 7));
      if (k == 7) chk("t3_code", key_code, 8);
    end
    hold(10'h3FB, 12);
    chk("t3_busy_held", key_busy, 1);
    chk("t3_code_kept", key_code, 8);
`ifndef KEYPAD_AUTOREPEAT_EN
    chk("t3_one_strobe", strobes - s0, 1);
`endif
    hold(10'h3FF, 14);
    chk("t3_idle", key_busy, 0);
    hold(10'h3FB, 10);
    chk("t3_code_2", key_code, 2);
    hold(10'h3FF, 14);

    // Release glitch on a held key 1.
    s0 = strobes;
    hold(10'h3FD, 10);
    hold(10'h3FF, 2);
    hold(10'h3FD, 10);
    chk("t4_busy_held", key_busy, 1);
    hold(10'h3FF, 14);
    chk("t4_code", key_code, 1);
`ifndef KEYPAD_AUTOREPEAT_EN
    chk("t4_one_strobe", strobes - s0, 1);
`endif

    // Code change inside the press debounce window restarts the count.
    A = 10'h3EF;
    cyc_wait();
    A = 10'h37F;
    for (int k = 2; k <= 10; k++) begin
      cyc_wait();
      chk("t5_valid", key_valid, (k == 8));
      if (k == 8) chk("t5_code", key_code, 7);
    end
    hold(10'h3FF, 14);

    // Reset two cycles into PRESS_DB with key 6 still held.
    hold(10'h3BF, 5);
    RST = 1'b1;
    #0;
    chk("t6_rst_valid", key_valid, 0);
    chk("t6_rst_busy", key_busy, 0);
    chk("t6_rst_code", key_code, 0);
    cyc_wait();
    chk("t6_rst_valid2", key_valid, 0);
    chk("t6_rst_busy2", key_busy, 0);
    cyc_wait();
    RST = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc_wait();
      chk("t6_valid", key_valid, (k == 7));
      if (k == 7) chk("t6_code", key_code, 6);
    end
    hold(10'h3FF, 14);

    // Key 9 held for 30 cycles.
    A = 10'h1FF;
    for (int k = 1; k <= 40; k++) begin
      cyc_wait();
      if (k == 30) A = 10'h3FF;
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("t7_valid", key_valid, (k inside {7, 15, 18, 21, 24, 27, 30}));
`else
      chk("t7_valid", key_valid, (k == 7));
`endif
    end
    chk("t7_code", key_code, 9);
    chk("t7_idle", key_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
